// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Holds the PC, requests words from
//             instruction memory, parks a returned word in a one-entry skid
//             buffer while ID is stalled, and loads the IF/ID register.
//             Redirects from ID never flush the word in flight (delay slot);
//             a redirect that arrives with no word delivered is remembered
//             in a pending register until the next delivery.
//  Ports    : clk, reset_n          - clock, async active-low reset
//             stall                 - ID does not consume IF/ID this cycle
//             npc_sel, npc_target   - redirect request / target from ID
//             imem_req, imem_addr   - fetch request / address (= PC)
//             imem_ready, imem_rdata- memory response
//             id_valid, id_instr,
//             id_pc, id_pc4         - IF/ID register
//             fetch_busy            - waiting on memory in FETCH
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        npc_sel,
    input  logic [31:0] npc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        fetch_busy
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        redirect;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;
    logic [31:0] target_aligned;
    logic [31:0] next_pc;

    // Redirects are only accepted while ID is actually advancing.
    assign redirect       = npc_sel && !stall;
    assign target_aligned = {npc_target[31:2], 2'b00};

    // A word reaches IF/ID either straight from memory or from the skid buffer.
    assign deliver       = !stall && ((state == HELD) || imem_ready);
    assign deliver_instr = (state == HELD) ? skid_instr : imem_rdata;
    assign deliver_pc    = (state == HELD) ? skid_pc    : pc;

    assign next_pc = redirect   ? target_aligned :
                     pend_valid ? pend_target    :
                                  pc + 32'd4;

    assign imem_addr  = pc;
    assign fetch_busy = (state == FETCH) && !imem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            imem_req    <= 1'b1;
            pc          <= PC_RESET;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
            skid_instr  <= 32'd0;
            skid_pc     <= 32'd0;
            id_valid    <= 1'b0;
            id_instr    <= 32'd0;
            id_pc       <= 32'd0;
            id_pc4      <= 32'd0;
        end else begin
            if (deliver) begin
                id_valid   <= 1'b1;
                id_instr   <= deliver_instr;
                id_pc      <= deliver_pc;
                id_pc4     <= deliver_pc + 32'd4;
                pc         <= next_pc;
                pend_valid <= 1'b0;
                state      <= FETCH;
                imem_req   <= 1'b1;
            end else if (!stall) begin
                // Nothing to hand over: insert a bubble, keep the payload.
                id_valid <= 1'b0;
                if (npc_sel) begin
                    pend_valid  <= 1'b1;
                    pend_target <= target_aligned;
                end
            end else if ((state == FETCH) && imem_ready) begin
                // ID is holding: park the returned word and stop requesting.
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
                state      <= HELD;
                imem_req   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, meaning the address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port stall  input  1  hazard-unit hold of the IF/ID register; ID does not consume this cycle.
REQ-005 SHALL have port npc_sel  input  1  redirect request from the ID-stage next-PC logic.
REQ-006 SHALL have port npc_target  input  32  redirect target address.
REQ-007 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-008 SHALL have port imem_addr  output  32  fetch address, always equal to the PC register.
REQ-009 SHALL have port imem_ready  input  1  imem_rdata valid this cycle for the current request.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-011 SHALL have port id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.
REQ-012 SHALL have port id_instr  output  32  IF/ID instruction.
REQ-013 SHALL have port id_pc  output  32  IF/ID instruction address.
REQ-014 SHALL have port id_pc4  output  32  id_pc + 4, registered.
REQ-015 SHALL have port fetch_busy  output  1  high while in FETCH with imem_ready low.

Function
REQ-016 SHALL implement states FETCH (imem_req=1, waiting for imem_ready) and HELD (word captured in skid buffer, imem_req=0).
REQ-017 In FETCH with imem_ready=1 and stall=0: SHALL load IF/ID with {1, imem_rdata, pc, pc+4}, advance PC (REQ-021), remain in FETCH.
REQ-018 In FETCH with imem_ready=1 and stall=1: SHALL capture imem_rdata and pc into the skid buffer, hold PC and IF/ID, go to HELD.
REQ-019 In HELD with stall=0: SHALL load IF/ID from the skid buffer, advance PC, go to FETCH; with stall=1, SHALL hold everything.
REQ-020 When stall=0 and no word is delivered this cycle: SHALL load IF/ID with id_valid=0 (bubble); id_instr/id_pc/id_pc4 retain their values.
REQ-021 Next PC on delivery SHALL be, in priority order: npc_target if npc_sel=1 and stall=0 this cycle; else the pending target if pending_valid=1; else pc+4 (32-bit wrap).
REQ-022 Delay-slot rule: the word delivered in the same cycle as a redirect, or the word outstanding when the redirect arrives, SHALL be delivered and never flushed.
REQ-023 npc_sel=1 with stall=0 and no delivery that cycle SHALL latch npc_target into pending register, set pending_valid=1; pending_valid SHALL clear on the next delivery.
REQ-024 A second redirect while pending_valid=1 SHALL overwrite the pending target.
REQ-025 npc_sel SHALL be ignored while stall=1.
REQ-026 npc_target[1:0] SHALL be forced to 2'b00 when loaded into PC or the pending register.
REQ-027 imem_addr and imem_req SHALL be driven from registers only (no combinational path from any input).
REQ-028 Fetch latency: with imem_ready tied high and stall=0, one instruction per cycle; word fetched at cycle N appears on id_* at cycle N+1.

Reset
REQ-029 On reset_n=0, asynchronously: pc=PC_RESET, state=FETCH, pending_valid=0, id_valid=0, id_instr=0, id_pc=0, id_pc4=0, skid buffer=0.
REQ-030 Reset asserted mid-fetch or in HELD SHALL discard the captured word; the first request after release SHALL be at PC_RESET with imem_req=1.

Verification
REQ-031 Release reset, imem_ready=1, stall=0 -> imem_addr 0x3000,0x3004,0x3008 on successive cycles; id_pc lags by one cycle; id_valid=1 from the second cycle.
REQ-032 Branch in ID at pc 0x3004 with npc_sel=1, npc_target=0x3040, delay slot 0x3008 delivered same cycle -> id_pc sequence 0x3004,0x3008,0x3040.
REQ-033 imem_ready low 3 cycles for 0x3008 while npc_sel=1 for one cycle (target 0x3100) -> fetch_busy=1, bubbles to ID, 0x3008 delivered, next imem_addr=0x3100.
REQ-034 stall=1 for 2 cycles as imem_ready=1 for 0x300C -> state HELD, imem_req=0, IF/ID unchanged; on stall release id_pc=0x300C, next imem_addr=0x3010.
REQ-035 npc_target=0x3043 -> PC loads 0x3040.
REQ-036 reset_n=0 asynchronously while in HELD -> all outputs at reset values before the next clock edge; after release imem_addr=0x3000.
